// File: rtl/alu_operand_stage.sv
// Execute-entry pipeline register ahead of the ALU: operand forwarding, immediate select,
// valid/ready handshake, and ownership of the MAC accumulator fed back from the ALU result.
module alu_operand_stage #(
    parameter int         XLEN    = 32,
    parameter int         REGADDR = 5,
    parameter logic [3:0] MAC_OP  = 4'b0100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic [XLEN-1:0]    RD1,
    input  logic [XLEN-1:0]    RD2,
    input  logic [XLEN-1:0]    Imm,
    input  logic               ALUSrc,
    input  logic [3:0]         ALUControlIn,
    input  logic [REGADDR-1:0] Rs1Addr,
    input  logic [REGADDR-1:0] Rs2Addr,
    input  logic               FwdValid,
    input  logic [REGADDR-1:0] FwdAddr,
    input  logic [XLEN-1:0]    FwdData,
    input  logic               Flush,
    input  logic               AccClear,
    input  logic [XLEN-1:0]    AluResult,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [XLEN-1:0]    A,
    output logic [XLEN-1:0]    B,
    output logic [3:0]         ALUControl,
    output logic [XLEN-1:0]    Accumulator
);

    logic               out_valid_reg, out_valid_next;
    logic [XLEN-1:0]    a_reg, a_next;
    logic [XLEN-1:0]    rs2_val_reg, rs2_val_next;
    logic [XLEN-1:0]    imm_reg, imm_next;
    logic               alu_src_reg, alu_src_next;
    logic [3:0]         ctrl_reg, ctrl_next;
    logic [REGADDR-1:0] rs1_addr_reg, rs1_addr_next;
    logic [REGADDR-1:0] rs2_addr_reg, rs2_addr_next;
    logic [XLEN-1:0]    acc_reg, acc_next;

    logic capture, retire, stall;

    // Index 0 is rs1, index 1 is rs2; both sources share the same forwarding rule.
    logic [XLEN-1:0]    rd_data   [2];
    logic [REGADDR-1:0] src_addr  [2];
    logic [REGADDR-1:0] held_addr [2];
    logic [XLEN-1:0]    src_val   [2];
    logic [1:0]         held_hit;

    assign rd_data[0]   = RD1;
    assign rd_data[1]   = RD2;
    assign src_addr[0]  = Rs1Addr;
    assign src_addr[1]  = Rs2Addr;
    assign held_addr[0] = rs1_addr_reg;
    assign held_addr[1] = rs2_addr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign src_val[gi]  = (FwdValid && FwdAddr == src_addr[gi] && src_addr[gi] != '0)
                                  ? FwdData : rd_data[gi];
            assign held_hit[gi] = FwdValid && FwdAddr == held_addr[gi] && held_addr[gi] != '0;
        end
    endgenerate

    assign InReady = rst_n && (!out_valid_reg || OutReady);
    assign capture = InValid && InReady && !Flush;
    assign retire  = out_valid_reg && OutReady;
    assign stall   = out_valid_reg && !OutReady;

    always_comb begin
        out_valid_next = out_valid_reg;
        a_next         = a_reg;
        rs2_val_next   = rs2_val_reg;
        imm_next       = imm_reg;
        alu_src_next   = alu_src_reg;
        ctrl_next      = ctrl_reg;
        rs1_addr_next  = rs1_addr_reg;
        rs2_addr_next  = rs2_addr_reg;
        acc_next       = acc_reg;

        if (capture) begin
            out_valid_next = 1'b1;
            a_next         = src_val[0];
            rs2_val_next   = src_val[1];
            imm_next       = Imm;
            alu_src_next   = ALUSrc;
            ctrl_next      = ALUControlIn;
            rs1_addr_next  = Rs1Addr;
            rs2_addr_next  = Rs2Addr;
        end else begin
            if (retire || Flush) begin
                out_valid_next = 1'b0;
            end
            // A held instruction keeps picking up writebacks to its sources.
            if (stall) begin
                if (held_hit[0]) a_next       = FwdData;
                if (held_hit[1]) rs2_val_next = FwdData;
            end
        end

        if (AccClear) begin
            acc_next = '0;
        end else if (retire && ctrl_reg == MAC_OP) begin
            acc_next = AluResult;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            a_reg         <= '0;
            rs2_val_reg   <= '0;
            imm_reg       <= '0;
            alu_src_reg   <= 1'b0;
            ctrl_reg      <= 4'b0000;
            rs1_addr_reg  <= '0;
            rs2_addr_reg  <= '0;
            acc_reg       <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            a_reg         <= a_next;
            rs2_val_reg   <= rs2_val_next;
            imm_reg       <= imm_next;
            alu_src_reg   <= alu_src_next;
            ctrl_reg      <= ctrl_next;
            rs1_addr_reg  <= rs1_addr_next;
            rs2_addr_reg  <= rs2_addr_next;
            acc_reg       <= acc_next;
        end
    end

    // B is muxed after the registers so a forwarded rs2 only shows when rs2 is selected.
    assign B           = alu_src_reg ? imm_reg : rs2_val_reg;
    assign OutValid    = out_valid_reg;
    assign A           = a_reg;
    assign ALUControl  = ctrl_reg;
    assign Accumulator = acc_reg;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Execute-entry pipeline register that sits directly upstream of the ALU.
- Each cycle it:
  - captures one decoded instruction from the decode stage;
  - resolves operand forwarding from writeback;
  - selects register or immediate for operand B;
  - presents stable A, B, ALUControl and Accumulator to the ALU under a valid/ready handshake.
- It owns the MAC accumulator register. The ALU's MAC result (ALUControl 4'b0100) is fed back and latched when that op retires from this stage.

Parameters:
- XLEN, 32, datapath width of operands, immediate, accumulator and result.
- REGADDR, 5, register-file address width.
- MAC_OP, 4'b0100, ALUControl encoding that updates the accumulator.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- InValid  input  1  decode presents an instruction
- InReady  output  1  stage can accept this cycle
- RD1  input  XLEN  register-file read data, rs1
- RD2  input  XLEN  register-file read data, rs2
- Imm  input  XLEN  sign-extended immediate
- ALUSrc  input  1  1 selects Imm as B, 0 selects rs2 value
- ALUControlIn  input  4  decoded ALU op
- Rs1Addr  input  REGADDR  source register 1
- Rs2Addr  input  REGADDR  source register 2
- FwdValid  input  1  writeback is writing a register this cycle
- FwdAddr  input  REGADDR  writeback destination
- FwdData  input  XLEN  writeback data
- Flush  input  1  discard held instruction (branch redirect)
- AccClear  input  1  synchronously zero the accumulator
- AluResult  input  XLEN  ALU Result, combinational feedback
- OutValid  output  1  A/B/ALUControl are valid for the ALU
- OutReady  input  1  downstream consumes the instruction this cycle
- A  output  XLEN  ALU operand A
- B  output  XLEN  ALU operand B
- ALUControl  output  4  ALU op
- Accumulator  output  XLEN  MAC accumulator

Behaviour:
- Reset (rst_n low, asynchronous):
  - OutValid=0; A, B, Accumulator = 0; ALUControl=4'b0000.
  - Internal rs2 value, ALUSrc, Rs1Addr and Rs2Addr are zeroed.
- InReady = !OutValid || OutReady. This is combinational. InReady is forced 0 while rst_n is low.
- Capture happens when InValid && InReady && !Flush. Latency is one cycle: OutValid=1 on the next edge.
  - Operand A = (FwdValid && FwdAddr==Rs1Addr && Rs1Addr!=0) ? FwdData : RD1.
  - rs2 value uses the same rule with Rs2Addr/RD2.
  - B = ALUSrc ? Imm : rs2 value.
- Retire happens when OutValid && OutReady. If there is no simultaneous capture, OutValid clears. A capture and a retire may occur in the same cycle; the new instruction then replaces the old with no bubble.
- Stall (OutValid && !OutReady):
  - Outputs hold.
  - Hold-time forwarding applies: if FwdValid, FwdAddr matches the held Rs1Addr (nonzero), A updates to FwdData.
  - Rs2 gets the same update, but B changes only when ALUSrc=0.
  - Register x0 is never forwarded.
- Flush:
  - On the next edge, OutValid=0 and any capture that cycle is suppressed.
  - Flush beats InValid.
  - A retire in the same cycle still counts for the accumulator (the ALU op completed).
- Accumulator update priority, evaluated per edge:
  1. AccClear: Accumulator=0.
  2. Else retire with ALUControl==MAC_OP: Accumulator = AluResult (XLEN bits, wrap-around, no saturation).
  3. Else hold.
  - Only one update per retired instruction. A stalled MAC never updates.
- A/B/ALUControl are don't-care to consumers when OutValid=0. Implementation keeps the last values (no toggling on bubbles).
- Reset asserted mid-operation: everything returns to reset values immediately. The in-flight instruction and accumulator contents are lost.

Test Plan:
- Basic capture:
  - Stimulus: reset release; InValid=1, RD1=5, RD2=7, ALUSrc=0, ALUControlIn=0000, OutReady=1.
  - Required: next cycle OutValid=1, A=5, B=7; InReady stays 1; back-to-back instructions every cycle with no bubble.
- Immediate and forwarding:
  - Stimulus: Rs1Addr=3, RD1=1, FwdValid=1, FwdAddr=3, FwdData=0xDEAD, ALUSrc=1, Imm=0xFFFFFFFC.
  - Required: A=0xDEAD, B=0xFFFFFFFC.
  - Repeat with Rs1Addr=FwdAddr=0: required A=RD1.
- Stall with hold-time forwarding:
  - Stimulus: hold OutReady=0 for 3 cycles. InReady=0 throughout. Mid-stall, FwdAddr matches held Rs2Addr with ALUSrc=0 and FwdData=0x42.
  - Required: B becomes 0x42; OutValid stays 1; the next InValid is not accepted until OutReady=1.
- MAC accumulation:
  - Stimulus: three MAC_OP retires with AluResult=10, 25, 0xFFFFFFFF.
  - Required: Accumulator=10, then 25, then 0xFFFFFFFF.
  - Required: a stalled MAC leaves Accumulator unchanged.
  - Required: AccClear concurrent with a MAC retire gives Accumulator=0.
- Flush:
  - Stimulus: Flush=1 with InValid=1 while holding a stalled instruction.
  - Required: next cycle OutValid=0, no capture.
  - Required: a Flush coinciding with a MAC retire still updates the Accumulator.
- Async reset mid-stall:
  - Stimulus: drop rst_n between clock edges.
  - Required: OutValid=0 and Accumulator=0 immediately; InReady=0 while reset is held.
